// File: rtl/fifo_stream_if.sv
// Stream-side bundle for fifo_stream: write port, read port, flush/clear
// controls, status flags and sticky error flags.
//
// Handshake: a write transfers on a rising edge when i_Data_Valid=1 and
// o_Full=0 (o_Full acts as the inverted ready). A read pops on a rising edge
// when i_Read=1 and o_Empty=0 (o_Empty acts as the inverted valid of o_Data).
// A request made against the wrong flag is dropped and recorded in
// o_Overflow / o_Underflow.
interface fifo_stream_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 18
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  i_Flush;
  logic                  i_Clear_Err;
  logic                  i_Data_Valid;
  logic [DATA_WIDTH-1:0] i_Data;
  logic                  o_Full;
  logic                  o_Almost_Full;
  logic                  i_Read;
  logic [DATA_WIDTH-1:0] o_Data;
  logic                  o_Empty;
  logic                  o_Almost_Empty;
  logic [CNT_WIDTH-1:0]  o_Count;
  logic                  o_Overflow;
  logic                  o_Underflow;

  // Producer/consumer side.
  modport master (
    output i_Flush, i_Clear_Err, i_Data_Valid, i_Data, i_Read,
    input  o_Full, o_Almost_Full, o_Data, o_Empty, o_Almost_Empty,
           o_Count, o_Overflow, o_Underflow
  );

  // FIFO side.
  modport slave (
    input  i_Flush, i_Clear_Err, i_Data_Valid, i_Data, i_Read,
    output o_Full, o_Almost_Full, o_Data, o_Empty, o_Almost_Empty,
           o_Count, o_Overflow, o_Underflow
  );
endinterface

// File: rtl/fifo_stream.sv
// fifo_stream: synchronous first-word-fall-through FIFO with arbitrary depth,
// occupancy count, almost-full/almost-empty flags, flush and sticky errors.
// Optional macro FIFO_DIAG_EN adds registered diagnostic outputs
// (o_Diag_State: 0=EMPTY 1=PARTIAL 2=FULL, plus both buffer addresses).
module fifo_stream #(
  parameter  int DEPTH        = 4,
  parameter  int DATA_WIDTH   = 18,
  parameter  int AFULL_LEVEL  = DEPTH - 1,
  parameter  int AEMPTY_LEVEL = 1,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  fifo_stream_if.slave          bus
`ifdef FIFO_DIAG_EN
  ,
  output logic [1:0]            o_Diag_State,
  output logic [ADDR_WIDTH-1:0] o_Diag_Buf_W_Addr,
  output logic [ADDR_WIDTH-1:0] o_Diag_Buf_R_Addr
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  AFULL_CNT = CNT_WIDTH'(AFULL_LEVEL);
  localparam logic [CNT_WIDTH-1:0]  AEMPTY_CNT = CNT_WIDTH'(AEMPTY_LEVEL);
  localparam logic [CNT_WIDTH-1:0]  ONE_CNT   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_n;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_n;
  logic [CNT_WIDTH-1:0]  count_q, count_n;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_n, udf_q, udf_n;
  logic                  wr_acc, rd_acc, ovf_evt, udf_evt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Accept/reject decisions and next-state of pointers, count and errors.
  always_comb begin
    wr_acc   = bus.i_Data_Valid && !full_q;
    rd_acc   = bus.i_Read && !empty_q;
    ovf_evt  = bus.i_Data_Valid && full_q;
    udf_evt  = bus.i_Read && empty_q;
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    count_n  = count_q;
    ovf_n    = ovf_q;
    udf_n    = udf_q;
    if (bus.i_Flush) begin
      // Flush discards this cycle's traffic and leaves the error flags alone.
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (wr_acc) wr_ptr_n = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_n = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_n = count_q + ONE_CNT;
        2'b01:   count_n = count_q - ONE_CNT;
        default: count_n = count_q;
      endcase
      // Clear first so that a new error in the same cycle wins.
      if (bus.i_Clear_Err) begin
        ovf_n = 1'b0;
        udf_n = 1'b0;
      end
      if (ovf_evt) ovf_n = 1'b1;
      if (udf_evt) udf_n = 1'b1;
    end
  end

  // Control state register; flags are derived from the next count so they
  // line up with o_Count after every edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      empty_q  <= (count_n == '0);
      aempty_q <= (count_n <= AEMPTY_CNT);
      full_q   <= (count_n == FULL_CNT);
      afull_q  <= (count_n >= AFULL_CNT);
      ovf_q    <= ovf_n;
      udf_q    <= udf_n;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst && !bus.i_Flush && wr_acc) begin
      mem[wr_ptr_q] <= bus.i_Data;
    end
  end

  assign bus.o_Data         = mem[rd_ptr_q];
  assign bus.o_Count        = count_q;
  assign bus.o_Empty        = empty_q;
  assign bus.o_Almost_Empty = aempty_q;
  assign bus.o_Full         = full_q;
  assign bus.o_Almost_Full  = afull_q;
  assign bus.o_Overflow     = ovf_q;
  assign bus.o_Underflow    = udf_q;

`ifdef FIFO_DIAG_EN
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } diag_state_t;

  diag_state_t state_q, state_n;

  // Occupancy state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_EMPTY;
    else       state_q <= state_n;
  end

  // Occupancy state follows the next count.
  always_comb begin
    state_n = ST_PARTIAL;
    if (count_n == '0)          state_n = ST_EMPTY;
    else if (count_n == FULL_CNT) state_n = ST_FULL;
  end

  assign o_Diag_State      = state_q;
  assign o_Diag_Buf_W_Addr = wr_ptr_q;
  assign o_Diag_Buf_R_Addr = rd_ptr_q;
`endif

endmodule
